// File: rtl/serial_encode.sv
// rtl/serial_encode.sv - thermostat link frame serialiser (192-bit frame, MSB first, strobed)
module serial_encode #(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          GAP_CLKS     = 16,
  parameter logic [31:0] PREAMBLE     = 32'hAAAA_AAAA,
  parameter logic [15:0] TYPE_1       = 16'hD391,
  parameter logic [15:0] TYPE_2       = 16'hD391,
  parameter logic [31:0] CONSTANT     = 32'h0DFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  bit_count,
  output logic        serial_data,
  output logic        serial_clock
);

  localparam int FRAME_BITS = 192;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [7:0]    LAST_BIT = 8'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [7:0]            bit_count_q, bit_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  data_q, data_d;
  logic                  strobe_q, strobe_d;
  logic [FRAME_BITS-1:0] frame;

  // Header fields are fixed so every emitted frame passes the receiver's header validation.
  assign frame = {PREAMBLE, TYPE_1, TYPE_2, CONSTANT, thermostat_id, room_temp,
                  set_temp, state, tail_1, tail_2, tail_3};

  // State and datapath registers; reset drops any partial frame without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= IDLE;
      shift_q     <= '0;
      cyc_q       <= '0;
      gap_q       <= '0;
      bit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      shift_q     <= shift_d;
      cyc_q       <= cyc_d;
      gap_q       <= gap_d;
      bit_count_q <= bit_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
    end
  end

  // Next-state logic; line outputs are derived from the next state so they are registered.
  always_comb begin
    fsm_d       = fsm_q;
    shift_d     = shift_q;
    cyc_d       = cyc_q;
    gap_d       = gap_q;
    bit_count_d = bit_count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (fsm_q)
      IDLE: begin
        // start wins over a simultaneous abort; fields are frozen here
        if (start) begin
          fsm_d       = SEND;
          shift_d     = frame;
          cyc_d       = '0;
          bit_count_d = '0;
          busy_d      = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          // bit_count keeps the strobes already issued until the next start
          fsm_d  = (GAP_CLKS == 0) ? IDLE : GAP;
          gap_d  = '0;
          busy_d = 1'b0;
        end else if (cyc_q == CYC_LAST) begin
          // end of a bit period: the strobe cycle just ended, advance to the next bit
          cyc_d       = '0;
          shift_d     = shift_q << 1;
          bit_count_d = bit_count_q + 8'd1;
          if (bit_count_q == LAST_BIT) begin
            fsm_d  = (GAP_CLKS == 0) ? IDLE : GAP;
            gap_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          fsm_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // The line only carries data in SEND; data changes only right after a strobe.
    data_d   = (fsm_d == SEND) ? shift_d[FRAME_BITS-1] : 1'b0;
    strobe_d = (fsm_d == SEND) && (cyc_d == CYC_LAST);
  end

  assign ready        = (fsm_q == IDLE) & ~reset;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bit_count    = bit_count_q;
  assign serial_data  = data_q;
  assign serial_clock = strobe_q;

endmodule

// File: tb/tb_serial_encode.sv
// tb/tb_serial_encode.sv - self-checking bench for serial_encode with a timestamp-based frame model
module tb_serial_encode;

  localparam int C         = 4;
  localparam int G         = 16;
  localparam int NB        = 192;
  localparam int C2        = 2;
  localparam int FRAME_CYC = NB * C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [31:0] thermostat_id = '0;
  logic [15:0] room_temp = '0;
  logic [15:0] set_temp = '0;
  logic [7:0]  state = '0;
  logic [7:0]  tail_1 = '0;
  logic [7:0]  tail_2 = '0;
  logic [7:0]  tail_3 = '0;

  logic        ready, busy, done, serial_data, serial_clock;
  logic [7:0]  bit_count;
  logic        ready2, busy2, done2, serial_data2, serial_clock2;
  logic [7:0]  bit_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // model of the default-parameter instance, kept as timestamps of the last start/abort
  logic         m_has = 1'b0;
  logic         m_aborted = 1'b0;
  int           m_t = 0;
  int           m_a = 0;
  int           m_ready_at = 0;
  logic [191:0] m_frame = '0;
  logic         exp_ready = 1'b0;

  // observers
  logic [191:0] mon_word = '0;
  int           mon_cnt = 0;
  int           n_done = 0;
  int           q_stb2[$];
  logic         q_bit2[$];
  int           q_done2[$];

  serial_encode dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
    .state(state), .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
    .ready(ready), .busy(busy), .done(done), .bit_count(bit_count),
    .serial_data(serial_data), .serial_clock(serial_clock)
  );

  serial_encode #(.CLKS_PER_BIT(C2), .GAP_CLKS(0)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .abort(abort2),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
    .state(state), .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
    .ready(ready2), .busy(busy2), .done(done2), .bit_count(bit_count2),
    .serial_data(serial_data2), .serial_clock(serial_clock2)
  );

  always #5 clock = ~clock;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] build_frame();
    return {32'hAAAA_AAAA, 16'hD391, 16'hD391, 32'h0DFF_FFFF, thermostat_id,
            room_temp, set_temp, state, tail_1, tail_2, tail_3};
  endfunction

  task automatic randomize_fields();
    thermostat_id = $urandom;
    room_temp     = 16'($urandom);
    set_temp      = 16'($urandom);
    state         = 8'($urandom);
    tail_1        = 8'($urandom);
    tail_2        = 8'($urandom);
    tail_3        = 8'($urandom);
  endtask

  // model update at each edge, from the inputs the DUT sees at that edge
  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      m_has      = 1'b0;
      m_aborted  = 1'b0;
      m_ready_at = edge_n;
    end else if (exp_ready && start) begin
      m_has      = 1'b1;
      m_aborted  = 1'b0;
      m_t        = edge_n;
      m_frame    = build_frame();
      m_ready_at = edge_n + FRAME_CYC + G;
    end else if (m_has && !m_aborted && abort && (edge_n - m_t) >= 1 && (edge_n - m_t) <= FRAME_CYC) begin
      m_aborted  = 1'b1;
      m_a        = edge_n;
      m_ready_at = edge_n + G;
    end
  end

  // every cycle: compare all outputs of the default instance with the model
  always @(negedge clock) begin
    int j;
    int lim;
    logic [7:0] e_bc;
    logic e_busy, e_done, e_data, e_clk;
    e_bc = '0; e_busy = 1'b0; e_done = 1'b0; e_data = 1'b0; e_clk = 1'b0;
    exp_ready = !reset && (edge_n >= m_ready_at);
    if (m_has) begin
      j   = edge_n - m_t;
      lim = m_aborted ? (m_a - m_t) : FRAME_CYC;
      if (j < lim) begin
        e_busy = 1'b1;
        e_data = m_frame[NB - 1 - j / C];
        e_clk  = (j % C) == (C - 1);
        e_bc   = 8'(j / C);
      end else if (!m_aborted && j == FRAME_CYC) begin
        e_done = 1'b1;
        e_bc   = 8'(NB);
      end else if (m_aborted) begin
        e_bc = 8'((m_a - m_t - 1) / C);
      end else begin
        e_bc = 8'(NB);
      end
    end
    check_int("cycle_outputs{ready,busy,done,data,clk,bit_count}",
              int'({ready, busy, done, serial_data, serial_clock, bit_count}),
              int'({exp_ready, e_busy, e_done, e_data, e_clk, e_bc}));
  end

  // sampled bit stream of both instances, as a receiver would see it
  always @(negedge clock) begin
    if (serial_clock) begin
      mon_word = {mon_word[190:0], serial_data};
      mon_cnt++;
    end
    if (done) n_done++;
    if (serial_clock2) begin
      q_stb2.push_back(edge_n + 1);
      q_bit2.push_back(serial_data2);
    end
    if (done2) q_done2.push_back(edge_n + 1);
  end

  task automatic start_frame(output int t);
    for (int n = 0; n < 2000; n++) begin
      if (ready) break;
      @(posedge clock); #1;
    end
    check_int("ready_before_start", int'(ready), 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    t = edge_n;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 3000; n++) begin
      if (ready) break;
      @(posedge clock); #1;
    end
    check_int("wait_ready_bound", int'(ready), 1);
  endtask

  task automatic clear_mon();
    mon_word = '0;
    mon_cnt  = 0;
    n_done   = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int t;
    int a;
    int o;
    int bad_t;
    int bad_b;
    logic [191:0] exp_frame;

    // reset values
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check_int("reset_ready", int'(ready), 0);
    check_int("reset_outputs", int'({busy, done, serial_data, serial_clock, bit_count}), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_int("ready_after_release", int'(ready), 1);
    @(posedge clock); #1;

    // nominal frame
    thermostat_id = 32'h0239_1F9F; room_temp = 16'h00C0; set_temp = 16'h00C8;
    state = 8'h64; tail_1 = 8'h50; tail_2 = 8'h0C; tail_3 = 8'h25;
    clear_mon();
    start_frame(t);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (done) break;
    end
    check_int("nominal_done_cycle", edge_n + 1 - t, 769);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (ready) break;
    end
    check_int("nominal_ready_cycle", edge_n + 1 - t, 785);
    check_int("nominal_strobes", mon_cnt, 192);
    check_vec("nominal_first_32", 192'(mon_word[191:160]), 192'(32'hAAAA_AAAA));
    check_vec("nominal_frame", mon_word,
              192'hAAAAAAAA_D391_D391_0DFFFFFF_02391F9F_00C0_00C8_64_50_0C_25);
    check_vec("rx_header", 192'(mon_word[191:96]), 192'(96'hAAAAAAAA_D391D391_0DFFFFFF));
    check_vec("rx_thermostat_id", 192'(mon_word[95:64]), 192'(32'h0239_1F9F));
    check_vec("rx_room_temp", 192'(mon_word[63:48]), 192'(16'h00C0));
    check_vec("rx_set_temp", 192'(mon_word[47:32]), 192'(16'h00C8));
    @(posedge clock); #1;

    // field changes after capture and an ignored start
    randomize_fields();
    exp_frame = build_frame();
    clear_mon();
    start_frame(t);
    thermostat_id = '1; room_temp = '1; set_temp = '1; state = '1;
    tail_1 = '1; tail_2 = '1; tail_3 = '1;
    while (edge_n < t + 99) begin @(posedge clock); #1; end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_ready();
    check_vec("held_fields_frame", mon_word, exp_frame);
    check_int("held_fields_done_count", n_done, 1);
    check_int("held_fields_strobes", mon_cnt, 192);

    // abort at bit_count 50
    randomize_fields();
    clear_mon();
    start_frame(t);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (bit_count == 8'd50) break;
    end
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    a = edge_n;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (ready) break;
    end
    check_int("abort_ready_delay", edge_n + 1 - a, G + 1);
    check_int("abort_strobes", mon_cnt, 50);
    check_int("abort_no_done", n_done, 0);
    check_int("abort_bit_count_held", int'(bit_count), 50);
    check_int("abort_line_low", int'({serial_data, serial_clock, busy}), 0);
    @(posedge clock); #1;

    // reset mid-frame at bit_count 100, then a full frame
    randomize_fields();
    clear_mon();
    start_frame(t);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (bit_count == 8'd100) break;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_int("midreset_outputs", int'({busy, done, serial_data, serial_clock, bit_count}), 0);
    check_int("midreset_ready", int'(ready), 1);
    check_int("midreset_no_done", n_done, 0);
    @(posedge clock); #1;
    randomize_fields();
    exp_frame = build_frame();
    clear_mon();
    start_frame(t);
    wait_ready();
    check_int("after_reset_strobes", mon_cnt, 192);
    check_vec("after_reset_frame", mon_word, exp_frame);

    // randomized frames, some aborted at random points, first one with start+abort together
    for (int it = 0; it < 6; it++) begin
      randomize_fields();
      exp_frame = build_frame();
      repeat ($urandom_range(0, 5)) begin @(posedge clock); #1; end
      clear_mon();
      abort = (it == 0);
      start_frame(t);
      abort = 1'b0;
      o = FRAME_CYC + 100;
      if (it % 2 == 1) begin
        o = $urandom_range(1, FRAME_CYC + G + 10);
        while (edge_n < t + o - 1) begin @(posedge clock); #1; end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
      end
      wait_ready();
      if (o > FRAME_CYC) begin
        check_vec("rand_frame", mon_word, exp_frame);
        check_int("rand_done_count", n_done, 1);
      end else begin
        check_int("rand_abort_strobes", mon_cnt, o / C);
        check_int("rand_abort_no_done", n_done, 0);
      end
    end

    // CLKS_PER_BIT=2, GAP_CLKS=0 instance: back-to-back frames with start held high
    randomize_fields();
    exp_frame = build_frame();
    q_stb2.delete(); q_bit2.delete(); q_done2.delete();
    check_int("c2_ready_idle", int'(ready2), 1);
    start2 = 1'b1;
    @(posedge clock); #1;
    t = edge_n;
    while (edge_n < t + NB * C2 + 1) begin
      if (edge_n == t + NB * C2 - 1) check_int("c2_ready_last_strobe", int'(ready2), 0);
      if (edge_n == t + NB * C2) check_int("c2_ready_at_done", int'(ready2), 1);
      @(posedge clock); #1;
    end
    start2 = 1'b0;
    repeat (NB * C2 + 10) @(posedge clock);
    #1;
    check_int("c2_strobe_count", q_stb2.size(), 2 * NB);
    bad_t = 0;
    bad_b = 0;
    for (int i = 0; i < q_stb2.size(); i++) begin
      if (q_stb2[i] != t + (i / NB) * (NB * C2 + 1) + ((i % NB) + 1) * C2) bad_t++;
      if (q_bit2[i] !== exp_frame[NB - 1 - (i % NB)]) bad_b++;
    end
    check_int("c2_strobe_timing_errors", bad_t, 0);
    check_int("c2_bit_errors", bad_b, 0);
    check_int("c2_done_count", q_done2.size(), 2);
    if (q_done2.size() == 2) begin
      check_int("c2_done1_cycle", q_done2[0] - t, NB * C2 + 1);
      check_int("c2_done2_cycle", q_done2[1] - t, 2 * (NB * C2 + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
